// File: rtl/instr_encoder.sv
// Encodes op requests into MIPS-I words queued in a DEPTH-entry FIFO.
// Optional two-word LI expansion (LUI + ORI) is enabled by defining INSTR_ENCODER_LI_EXPAND_EN.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err_illegal,
  output logic [15:0] word_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef INSTR_ENCODER_LI_EXPAND_EN
  typedef enum logic {IDLE = 1'b0, LI2 = 1'b1} state_e;
`else
  typedef enum logic {IDLE = 1'b0} state_e;
`endif

  state_e        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          err_q, err_d;
  logic [15:0]   word_cnt_q, word_cnt_d;

  logic          accept;
  logic          pop;
  logic          push;
  logic [31:0]   push_word;
  logic [31:0]   dec_word;
  logic          dec_legal;

`ifdef INSTR_ENCODER_LI_EXPAND_EN
  logic          dec_is_li;
  logic [4:0]    li_rt_q, li_rt_d;
  logic [15:0]   li_lo_q, li_lo_d;
`else
  logic          unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:26];
`endif

  assign accept = in_valid & in_ready_q;
  assign pop    = (count_q != '0) & out_ready;

  // Unused fields of each format are forced to their fixed constants here.
  always_comb begin
    dec_word  = '0;
    dec_legal = 1'b1;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
    dec_is_li = 1'b0;
`endif
    case (in_op)
      5'd0:  dec_word = '0;
      5'd1:  dec_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
      5'd2:  dec_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
      5'd3:  dec_word = {6'b000000, in_rs, 15'b0, 6'b001000};
      5'd4:  dec_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
      5'd5:  dec_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
      5'd6:  dec_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
      5'd7:  dec_word = {6'b001111, 5'b00000, in_rt, in_imm[15:0]};
      5'd8:  dec_word = {6'b001010, in_rs, in_rt, in_imm[15:0]};
      5'd9:  dec_word = {6'b001011, in_rs, in_rt, in_imm[15:0]};
      5'd10: dec_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
      5'd11: dec_word = {6'b000101, in_rs, in_rt, in_imm[15:0]};
      5'd12: dec_word = {6'b000001, in_rs, 5'b00001, in_imm[15:0]};
      5'd13: dec_word = {6'b000001, in_rs, 5'b00000, in_imm[15:0]};
      5'd14: dec_word = {6'b000111, in_rs, 5'b00000, in_imm[15:0]};
      5'd15: dec_word = {6'b000110, in_rs, 5'b00000, in_imm[15:0]};
      5'd16: dec_word = {6'b000010, in_imm[25:0]};
      5'd17: dec_word = {6'b000011, in_imm[25:0]};
`ifdef INSTR_ENCODER_LI_EXPAND_EN
      5'd18: begin
        dec_word  = {6'b001111, 5'b00000, in_rt, in_imm[31:16]};
        dec_is_li = 1'b1;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef INSTR_ENCODER_LI_EXPAND_EN
      IDLE: if (accept && dec_is_li) state_d = LI2;
      LI2:  if (count_q < DEPTH_C) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // in_ready is registered from next-cycle state/count so out_ready never reaches it combinationally.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        push      = accept & dec_legal;
        push_word = dec_word;
        err_d     = accept & ~dec_legal;
      end
`ifdef INSTR_ENCODER_LI_EXPAND_EN
      LI2: begin
        push      = (count_q < DEPTH_C);
        push_word = {6'b001101, li_rt_q, li_rt_q, li_lo_q};
      end
`endif
      default: ;
    endcase

    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    word_cnt_d = word_cnt_q + 16'(pop);
    in_ready_d = (state_d == IDLE) && (count_d < DEPTH_C);

`ifdef INSTR_ENCODER_LI_EXPAND_EN
    li_rt_d = li_rt_q;
    li_lo_d = li_lo_q;
    if (accept && dec_is_li) begin
      li_rt_d = in_rt;
      li_lo_d = in_imm[15:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
      li_rt_q    <= '0;
      li_lo_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
      li_rt_q    <= li_rt_d;
      li_lo_q    <= li_lo_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != '0);
  assign out_instr   = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
  assign err_illegal = err_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
`ifdef INSTR_ENCODER_LI_EXPAND_EN
  localparam bit LI_EN = 1'b1;
`else
  localparam bit LI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        err_illegal;
  logic [15:0] word_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [15:0] model_cnt = '0;
  bit          err_exp = 1'b0;
  logic [31:0] sb_w0, sb_w1, sb_got;
  int          sb_n;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .err_illegal(err_illegal),
    .word_cnt   (word_cnt)
  );

  // Reference encoder built from field positions and opcode numbers; returns word count, 0 if illegal.
  function automatic int model_encode(input logic [4:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [31:0] imm,
                                      output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] itab [0:7];
    logic [31:0] r, t, d, lo, opc, rtc;
    int          o;
    itab = '{32'd13, 32'd35, 32'd43, 32'd15, 32'd10, 32'd11, 32'd4, 32'd5};
    o  = int'(op);
    r  = 32'(rs) << 21;
    t  = 32'(rt) << 16;
    d  = 32'(rd) << 11;
    lo = imm & 32'h0000FFFF;
    w0 = '0;
    w1 = '0;
    if (o == 0) return 1;
    if (o == 1) begin w0 = r | t | d | 32'd33; return 1; end
    if (o == 2) begin w0 = r | t | d | 32'd35; return 1; end
    if (o == 3) begin w0 = r | 32'd8; return 1; end
    if (o >= 4 && o <= 11) begin
      w0 = (itab[o-4] << 26) | ((o == 7) ? 32'h0 : r) | t | lo;
      return 1;
    end
    if (o >= 12 && o <= 15) begin
      opc = (o <= 13) ? 32'd1 : ((o == 14) ? 32'd7 : 32'd6);
      rtc = (o == 12) ? (32'd1 << 16) : 32'h0;
      w0  = (opc << 26) | r | rtc | lo;
      return 1;
    end
    if (o == 16 || o == 17) begin
      w0 = (32'(o - 14) << 26) | (imm & 32'h03FFFFFF);
      return 1;
    end
    if (o == 18 && LI_EN) begin
      w0 = (32'd15 << 26) | t | (imm >> 16);
      w1 = (32'd13 << 26) | (32'(rt) << 21) | t | lo;
      return 2;
    end
    return 0;
  endfunction

  // Scoreboard: samples handshakes mid-cycle, predicts pops, err pulses and out_valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = '0;
      err_exp   = 1'b0;
    end else begin
      checks++;
      if (err_illegal !== err_exp) begin
        errors++;
        $display("[TB] FAIL sb_err_illegal: got %b want %b at %0t", err_illegal, err_exp, $time);
      end
      err_exp = 1'b0;
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL sb_out_valid: got %b want %b at %0t", out_valid, exp_q.size() != 0, $time);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected_word: got %h want none at %0t", out_instr, $time);
        end else begin
          sb_got = exp_q.pop_front();
          if (out_instr !== sb_got) begin
            errors++;
            $display("[TB] FAIL sb_word: got %h want %h at %0t", out_instr, sb_got, $time);
          end
        end
        model_cnt++;
      end
      if (in_valid && in_ready === 1'b1) begin
        sb_n = model_encode(in_op, in_rs, in_rt, in_rd, in_imm, sb_w0, sb_w1);
        if (sb_n == 0) err_exp = 1'b1;
        if (sb_n >= 1) exp_q.push_back(sb_w0);
        if (sb_n == 2) exp_q.push_back(sb_w1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm);
    bit done;
    done     = 1'b0;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = (in_ready === 1'b1);
      tick();
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: got no accept want accept for op %0d", op);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid === 1'b1; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got out_valid=%b pending=%0d want 0/0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_op = 5'd1;
    out_ready = 1'b1;
    tick();
    checks += 5;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_out_instr: got %h want 0", out_instr); end
    if (err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b want 0", err_illegal); end
    if (word_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_word_cnt: got %h want 0", word_cnt); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addu();
    out_ready = 1'b1;
    send(5'd1, 5'd1, 5'd2, 5'd3, 32'hDEAD0000);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addu_valid: got %b want 1", out_valid); end
    if (out_instr !== 32'h00221821) begin errors++; $display("[TB] FAIL addu_word: got %h want 00221821", out_instr); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addu_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_order();
    out_ready = 1'b0;
    send(5'd4, 5'd0, 5'd8, 5'd17, 32'h55551234);
    send(5'd12, 5'd4, 5'd7, 5'd9, 32'hABCDFFFE);
    tick();
    tick();
    checks++;
    if (out_instr !== 32'h34081234) begin errors++; $display("[TB] FAIL order_head_hold: got %h want 34081234", out_instr); end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_instr !== 32'h0481FFFE) begin errors++; $display("[TB] FAIL order_second: got %h want 0481FFFE", out_instr); end
    drain();
  endtask

  task automatic test_li();
    out_ready = 1'b1;
    send(5'd18, 5'd3, 5'd9, 5'd2, 32'h12345678);
    if (LI_EN) begin
      checks += 2;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL li_ready_low: got %b want 0", in_ready); end
      if (out_instr !== 32'h3C091234) begin errors++; $display("[TB] FAIL li_lui: got %h want 3C091234", out_instr); end
      tick();
      checks += 2;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL li_ready_back: got %b want 1", in_ready); end
      if (out_instr !== 32'h35295678) begin errors++; $display("[TB] FAIL li_ori: got %h want 35295678", out_instr); end
    end else begin
      checks += 2;
      if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL li_illegal_pulse: got %b want 1", err_illegal); end
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL li_no_word: got %b want 0", out_valid); end
      tick();
      checks++;
      if (err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL li_pulse_end: got %b want 0", err_illegal); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    bit done;
    do_reset();
    acc = 0;
    out_ready = 1'b0;
    in_op = 5'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (in_ready === 1'b1) acc++;
      tick();
    end
    checks += 2;
    if (acc != DEPTH) begin errors++; $display("[TB] FAIL full_accepts: got %0d want %0d", acc, DEPTH); end
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      done = (in_ready === 1'b1);
      if (done) acc++;
      tick();
    end
    in_valid = 1'b0;
    drain();
    checks += 2;
    if (acc != 5) begin errors++; $display("[TB] FAIL fifth_accept: got %0d want 5", acc); end
    if (word_cnt !== 16'd5) begin errors++; $display("[TB] FAIL word_cnt_five: got %0d want 5", word_cnt); end
  endtask

  task automatic test_illegal();
    logic [15:0] start_cnt;
    logic [31:0] head;
    start_cnt = model_cnt;
    out_ready = 1'b0;
    send(5'd1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    send(5'd2, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    head = exp_q[0];
    send(5'd25, 5'd1, 5'd1, 5'd1, 32'hFFFFFFFF);
    checks += 2;
    if (err_illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_pulse: got %b want 1", err_illegal); end
    if (out_instr !== head) begin errors++; $display("[TB] FAIL illegal_head: got %h want %h", out_instr, head); end
    tick();
    checks++;
    if (err_illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_pulse_end: got %b want 0", err_illegal); end
    drain();
    checks++;
    if (word_cnt !== 16'(start_cnt + 16'd2)) begin
      errors++;
      $display("[TB] FAIL illegal_count: got %0d want %0d", word_cnt, start_cnt + 16'd2);
    end
  endtask

  task automatic test_reset_li2();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(5'd1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    if (LI_EN) begin
      send(5'd18, 5'd0, 5'd9, 5'd0, 32'h12345678);
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL li2_stall: got %b want 0", in_ready); end
    end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); end
    if (word_cnt !== 16'h0) begin errors++; $display("[TB] FAIL midrst_word_cnt: got %0d want 0", word_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL postrst_no_ori: got %b want 0", out_valid); end
    if (word_cnt !== 16'h0) begin errors++; $display("[TB] FAIL postrst_word_cnt: got %0d want 0", word_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    checks++;
    if (word_cnt !== model_cnt) begin errors++; $display("[TB] FAIL random_word_cnt: got %0d want %0d", word_cnt, model_cnt); end
  endtask

  initial begin
    $display("[TB] start, LI expansion %0s", LI_EN ? "enabled" : "disabled");
    test_reset();
    test_addu();
    test_order();
    test_li();
    test_back_to_back();
    test_illegal();
    test_reset_li2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, setting the number of output FIFO entries, a power of two from 2 to 16.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid&in_ready at edge.
- in_op  in  5  operation select (REQ-004).
- in_rs / in_rt / in_rd  in  5 each  register fields.
- in_imm  in  32  imm16 in [15:0]; jump target in [25:0]; LI value in [31:0].
- out_valid  out  1  out_instr holds a word.
- out_ready  in  1  consumer takes the word when out_valid&out_ready.
- out_instr  out  32  encoded MIPS word.
- err_illegal  out  1  one-cycle pulse on an illegal op.
- word_cnt  out  16  count of words popped, wraps at 0xFFFF->0.

Function
REQ-003 The block SHALL encode each request into MIPS-I words and queue them in a DEPTH-entry FIFO, first in first out.
REQ-004 The op codes SHALL be:
- 0 NOP = 0x00000000.
- 1 ADDU: {000000,rs,rt,rd,00000,100001}.
- 2 SUBU: funct 100011.
- 3 JR: {000000,rs,15'b0,001000}.
- I-type {op,rs,rt,imm16}: 4 ORI 001101; 5 LW 100011; 6 SW 101011; 7 LUI 001111 with rs=0; 8 SLTI 001010; 9 SLTIU 001011; 10 BEQ 000100; 11 BNE 000101.
- 12 BGEZ: op 000001, rt=00001.
- 13 BLTZ: op 000001, rt=00000.
- 14 BGTZ: 000111, rt=0.
- 15 BLEZ: 000110, rt=0.
- 16 J: {000010,imm[25:0]}.
- 17 JAL: {000011,imm[25:0]}.
- 18 LI: see Configuration.
- 19-31: illegal.
REQ-005 Input fields not used by an op SHALL be ignored and forced to the constants given above.
REQ-006 The FSM SHALL have two states, IDLE and LI2, and SHALL leave reset in IDLE.
REQ-007 in_ready SHALL equal (state==IDLE) && (count<DEPTH), a registered condition with no combinational path from out_ready.
REQ-008 An accepted legal single-word op SHALL push one word, and out_valid SHALL assert on the next cycle if the FIFO was empty.
REQ-009 A pop and a push in the same cycle SHALL leave count unchanged, and the pushed word SHALL follow all older words.
REQ-010 out_valid SHALL equal count!=0, and out_instr SHALL show the head entry, held stable while out_valid&!out_ready.
REQ-011 An accepted illegal op SHALL push nothing and SHALL pulse err_illegal high for exactly one cycle, the cycle after acceptance.
REQ-012 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-013 word_cnt SHALL increment on each pop.

Reset
REQ-014 While rst_n=0, the block SHALL force: state=IDLE; FIFO empty; in_ready=0; out_valid=0; out_instr=0; err_illegal=0; word_cnt=0.
REQ-015 A reset asserted mid-operation, including in LI2, SHALL discard all queued and pending words.
REQ-016 in_ready SHALL rise in the first clock edge after rst_n deasserts.

Configuration
REQ-017 The block SHALL support one macro, INSTR_ENCODER_LI_EXPAND_EN.
REQ-018 With INSTR_ENCODER_LI_EXPAND_EN defined, accepting LI SHALL:
- push LUI rt,imm[31:16];
- enter LI2, holding in_ready=0;
- on the next cycle with count<DEPTH, push ORI rt,rt,imm[15:0] and return to IDLE.
REQ-019 With INSTR_ENCODER_LI_EXPAND_EN defined, LI2 SHALL wait while the FIFO is full.
REQ-020 Without INSTR_ENCODER_LI_EXPAND_EN, op 18 SHALL be illegal per REQ-011 and the LI2 state SHALL not exist.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADDU rs=1 rt=2 rd=3, out_ready=1 -> out_instr=0x00221821 one cycle after acceptance.
- ORI rt=8 imm=0x1234, then BGEZ rs=4 imm=0xFFFE -> 0x34081234, then 0x0481FFFE, in order.
- LI rt=9 imm=0x12345678 with the macro -> 0x3C091234, then 0x35295678; in_ready low for exactly one cycle. Same request without the macro -> err_illegal pulse and no word.
- out_ready=0, five back-to-back NOPs, DEPTH=4 -> in_ready=0 after the 4th. Raise out_ready -> 5th accepted; word_cnt reaches 5.
- in_op=25 -> err_illegal=1 for one cycle, count unchanged.
- rst_n pulsed low while in LI2 with 3 words queued -> out_valid=0, word_cnt=0, no ORI emitted after release.
